// File: rtl/mem_miss_pkg.sv
// Shared types and constants for the cache-miss sequencer.
package mem_miss_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WB     = 3'd1,
        S_WB_GAP = 3'd2,
        S_RF     = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } mm_state_e;

    localparam int LINE_BYTES          = 16;
    localparam int WORDS_PER_LINE      = 4;
    localparam int OFFSET_BITS         = $clog2(LINE_BYTES);
    localparam int DEFAULT_MEM_TIMEOUT = 16;

    function automatic logic [31:0] victim_word(input logic [127:0] line, input logic [1:0] k);
        return line[{k, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/mem_access_tracker.sv
// Tracks one memory access: the ready-low handshake flag and the timeout counter.
module mem_access_tracker #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic req,
    input  logic mem_ready,
    output logic complete,
    output logic timeout
);

    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    logic       seen_low_q, seen_low_d;
    logic [7:0] cnt_q, cnt_d;

    // Both restart whenever no request is on the bus, so each access starts fresh.
    always_comb begin
        seen_low_d = seen_low_q;
        cnt_d      = cnt_q;
        if (clr || !req) begin
            seen_low_d = 1'b0;
            cnt_d      = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
            if (!mem_ready) begin
                seen_low_d = 1'b1;
            end else begin
                seen_low_d = seen_low_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seen_low_q <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            seen_low_q <= seen_low_d;
            cnt_q      <= cnt_d;
        end
    end

    // A ready-high before any low sample is the idle level, not a completion.
    assign complete = req & seen_low_q & mem_ready;
    assign timeout  = req & ~complete & (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_miss_handler.sv
// Cache-miss sequencer: optional four-word victim writeback, then one block refill.
module mem_miss_handler
    import mem_miss_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         miss_req,
    input  logic [31:0]  miss_addr,
    input  logic         dirty,
    input  logic [31:0]  victim_addr,
    input  logic [127:0] victim_data,
    output logic         miss_ack,
    output logic         refill_valid,
    output logic [127:0] refill_data,
    output logic         busy,
    output logic         err,
    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic [127:0] mem_block_rdata,
    input  logic         mem_ready,
    output logic         mem_clr
);

    localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_LINE - 1);

    mm_state_e state_q, state_d;
    logic [1:0]             k_q, k_d;
    logic [31:OFFSET_BITS]  miss_line_q, miss_line_d;
    logic [31:OFFSET_BITS]  victim_line_q, victim_line_d;
    logic [127:0]           victim_data_q, victim_data_d;
    logic [127:0]           refill_data_q, refill_data_d;
    logic                   miss_ack_q, miss_ack_d, refill_valid_q, refill_valid_d;
    logic                   busy_q, busy_d, err_q, err_d, mem_clr_q, mem_clr_d;
    logic                   mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [31:0]            mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic                   acc_complete_s, acc_timeout_s;
    logic                   unused_s;

    assign unused_s = ^{miss_addr[OFFSET_BITS-1:0], victim_addr[OFFSET_BITS-1:0]};

    mem_access_tracker #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .req       (mem_read_q | mem_write_q),
        .mem_ready (mem_ready),
        .complete  (acc_complete_s),
        .timeout   (acc_timeout_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and latched-context logic; clr overrides everything.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        miss_line_d   = miss_line_q;
        victim_line_d = victim_line_q;
        victim_data_d = victim_data_q;
        refill_data_d = refill_data_q;
        if (clr) begin
            state_d = S_IDLE;
            k_d     = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (miss_req) begin
                        miss_line_d   = miss_addr[31:OFFSET_BITS];
                        victim_line_d = victim_addr[31:OFFSET_BITS];
                        victim_data_d = victim_data;
                        k_d           = 2'd0;
                        state_d       = dirty ? S_WB : S_RF;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_WB: begin
                    if (acc_timeout_s)       state_d = S_ERR;
                    else if (acc_complete_s) state_d = S_WB_GAP;
                    else                     state_d = S_WB;
                end
                S_WB_GAP: begin
                    if (k_q == LAST_WORD) begin
                        state_d = S_RF;
                    end else begin
                        k_d     = k_q + 2'd1;
                        state_d = S_WB;
                    end
                end
                S_RF: begin
                    if (acc_timeout_s) begin
                        state_d = S_ERR;
                    end else if (acc_complete_s) begin
                        refill_data_d = mem_block_rdata;
                        state_d       = S_DONE;
                    end else begin
                        state_d = S_RF;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from the next state so every output leaves a flop.
    always_comb begin
        mem_read_d     = (state_d == S_RF);
        mem_write_d    = (state_d == S_WB);
        miss_ack_d     = (state_d == S_DONE);
        refill_valid_d = (state_d == S_DONE);
        busy_d         = (state_d != S_IDLE);
        err_d          = (state_d == S_ERR);
        mem_clr_d      = clr | acc_timeout_s;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        if (state_d == S_WB) begin
            mem_addr_d  = {victim_line_d, k_d, 2'b00};
            mem_wdata_d = victim_word(victim_data_d, k_d);
        end else if (state_d == S_RF) begin
            mem_addr_d  = {miss_line_d, {OFFSET_BITS{1'b0}}};
        end else begin
            mem_addr_d  = mem_addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q            <= 2'd0;
            miss_line_q    <= '0;
            victim_line_q  <= '0;
            victim_data_q  <= 128'd0;
            refill_data_q  <= 128'd0;
            miss_ack_q     <= 1'b0;
            refill_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            mem_clr_q      <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_addr_q     <= 32'd0;
            mem_wdata_q    <= 32'd0;
        end else begin
            k_q            <= k_d;
            miss_line_q    <= miss_line_d;
            victim_line_q  <= victim_line_d;
            victim_data_q  <= victim_data_d;
            refill_data_q  <= refill_data_d;
            miss_ack_q     <= miss_ack_d;
            refill_valid_q <= refill_valid_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
            mem_clr_q      <= mem_clr_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
        end
    end

    assign miss_ack     = miss_ack_q;
    assign refill_valid = refill_valid_q;
    assign refill_data  = refill_data_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_clr      = mem_clr_q;

endmodule

// File: tb/tb_mem_miss_handler.sv
// Bench for mem_miss_handler: 3-cycle memory model plus a line-level reference memory.
module tb_mem_miss_handler;

    logic         clk = 1'b0;
    logic         rst, clr, miss_req, dirty, mem_ready;
    logic [31:0]  miss_addr, victim_addr;
    logic [127:0] victim_data, mem_block_rdata;
    logic         miss_ack, refill_valid, busy, err, mem_read, mem_write, mem_clr;
    logic [127:0] refill_data;
    logic [31:0]  mem_addr, mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]  mem  [logic [31:0]];
    logic [31:0]  refm [logic [31:0]];
    logic [63:0]  wlog [$];
    logic [31:0]  rlog [$];
    logic         stuck_high = 1'b0;
    int           mm_phase;
    logic [127:0] last_refill;

    always #5 clk = ~clk;

    mem_miss_handler #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .clr(clr), .miss_req(miss_req), .miss_addr(miss_addr),
        .dirty(dirty), .victim_addr(victim_addr), .victim_data(victim_data),
        .miss_ack(miss_ack), .refill_valid(refill_valid), .refill_data(refill_data),
        .busy(busy), .err(err), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_block_rdata(mem_block_rdata),
        .mem_ready(mem_ready), .mem_clr(mem_clr)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'd0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : 32'd0;
    endfunction

    function automatic logic [127:0] ref_line(input logic [31:0] a);
        return {ref_rd(a + 32'd12), ref_rd(a + 32'd8), ref_rd(a + 32'd4), ref_rd(a)};
    endfunction

    task automatic preload(input logic [31:0] a, input logic [127:0] line);
        for (int k = 0; k < 4; k++) begin
            mem[a + 32'(4*k)]  = line[32*k +: 32];
            refm[a + 32'(4*k)] = line[32*k +: 32];
        end
    endtask

    // Memory: ready high on the first request cycle, low for two, then high with the result.
    initial begin : mem_model
        mem_ready       = 1'b1;
        mem_block_rdata = 128'd0;
        mm_phase        = 0;
        forever begin
            @(posedge clk); #1;
            if (!(mem_read || mem_write)) begin
                mm_phase  = 0;
                mem_ready = 1'b1;
            end else begin
                mm_phase++;
                mem_ready = (stuck_high || mm_phase == 1 || mm_phase >= 4);
                if (!stuck_high && mm_phase == 4) begin
                    if (mem_write) begin
                        mem[mem_addr] = mem_wdata;
                        wlog.push_back({mem_addr, mem_wdata});
                    end else begin
                        mem_block_rdata = {mem_rd(mem_addr + 32'd12), mem_rd(mem_addr + 32'd8),
                                           mem_rd(mem_addr + 32'd4), mem_rd(mem_addr)};
                        rlog.push_back(mem_addr);
                    end
                end
            end
        end
    end

    // One miss over a fixed 40-cycle window; cycle 0 is the cycle miss_req is sampled.
    task automatic run_miss(input logic [31:0] ma, input logic d, input logic [31:0] va,
                            input logic [127:0] vd, input logic intrude);
        logic [31:0]  ml, vl;
        logic [127:0] exp_line, got_line;
        int           acks, ack_c;
        logic         rv;
        ml = {ma[31:4], 4'h0};
        vl = {va[31:4], 4'h0};
        if (!refm.exists(ml)) preload(ml, {$urandom, $urandom, $urandom, $urandom});
        if (d) for (int k = 0; k < 4; k++) refm[vl + 32'(4*k)] = vd[32*k +: 32];
        exp_line = ref_line(ml);
        wlog.delete();
        rlog.delete();
        miss_addr = ma; dirty = d; victim_addr = va; victim_data = vd; miss_req = 1'b1;
        acks = 0; ack_c = -1; rv = 1'b0; got_line = 128'd0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            miss_req = (intrude && c == 3);
            if (intrude && c == 3) miss_addr = ma ^ 32'h0000_0100;
            if (miss_ack) begin
                acks++;
                if (ack_c < 0) begin
                    ack_c = c; rv = refill_valid; got_line = refill_data;
                end
            end
        end
        miss_req = 1'b0;
        chk("ack_count", acks, 1);
        chk("ack_cycle", ack_c, d ? 25 : 5);
        chk("refill_valid", rv, 1'b1);
        chk("refill_data", got_line, exp_line);
        chk("busy_after", busy, 1'b0);
        chk("wr_count", wlog.size(), d ? 4 : 0);
        for (int k = 0; k < wlog.size() && k < 4; k++)
            chk("wr_word", wlog[k], {vl + 32'(4*k), vd[32*k +: 32]});
        chk("rd_count", rlog.size(), 1);
        if (rlog.size() > 0) chk("rd_addr", rlog[0], ml);
        last_refill = exp_line;
    endtask

    initial begin
        logic [127:0] w;
        logic [31:0]  ma, va;
        int           acks;
        rst = 1'b0; clr = 1'b0; miss_req = 1'b0; dirty = 1'b0;
        miss_addr = 32'd0; victim_addr = 32'd0; victim_data = 128'd0;
        last_refill = 128'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {miss_ack, refill_valid, busy, err, mem_read, mem_write, mem_clr}, 7'd0);
        chk("reset_addr", mem_addr, 32'd0);
        chk("reset_wdata", mem_wdata, 32'd0);
        chk("reset_refill", refill_data, 128'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Clean miss and dirty miss with readback of the written victim line.
        preload(32'h0000_1230, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        run_miss(32'h0000_1234, 1'b0, 32'd0, 128'd0, 1'b0);
        chk("clean_line", refill_data, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        w = 128'h33333333_22222222_11111111_00000000;
        run_miss(32'h0000_3000, 1'b1, 32'h0000_2000, w, 1'b0);
        run_miss(32'h0000_2008, 1'b0, 32'd0, 128'd0, 1'b0);
        chk("wb_readback", refill_data, w);

        // Second miss_req during writeback is dropped.
        run_miss(32'h0000_7000, 1'b1, 32'h0000_7400, {$urandom, $urandom, $urandom, $urandom}, 1'b1);

        // Timeout with mem_ready stuck high, then clr recovery.
        stuck_high = 1'b1;
        miss_addr = 32'h0000_4000; dirty = 1'b0; miss_req = 1'b1;
        acks = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            miss_req = 1'b0;
            if (miss_ack) acks++;
            if (c == 16) chk("to_err_before", {err, mem_read}, 2'b01);
            if (c == 17) chk("to_err_set", {err, mem_clr, mem_read}, 3'b110);
            if (c == 18) chk("to_mem_clr_once", mem_clr, 1'b0);
            if (c == 30) chk("to_err_busy_hold", {err, busy}, 2'b11);
        end
        chk("to_no_ack", acks, 0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_recover", {err, busy, mem_clr}, 3'b001);
        @(posedge clk); #1;
        chk("clr_mem_clr_once", mem_clr, 1'b0);
        stuck_high = 1'b0;
        run_miss(32'h0000_1230, 1'b0, 32'd0, 128'd0, 1'b0);

        // clr during the third writeback word: no ack, refill_data kept, words 0 and 1 written.
        w = {$urandom, $urandom, $urandom, $urandom};
        wlog.delete();
        miss_addr = 32'h0000_6000; dirty = 1'b1; victim_addr = 32'h0000_6800; victim_data = w;
        miss_req = 1'b1;
        acks = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            miss_req = 1'b0;
            if (miss_ack) acks++;
            if (c == 12) begin
                chk("clr_wb2_active", {mem_write, mem_addr}, {1'b1, 32'h0000_6808});
                clr = 1'b1;
            end
            if (c == 13) begin
                clr = 1'b0;
                chk("clr_wb2_drop", {mem_write, mem_read, busy}, 3'b000);
            end
        end
        chk("clr_wb2_no_ack", acks, 0);
        chk("clr_wb2_refill_kept", refill_data, last_refill);
        chk("clr_wb2_wr_count", wlog.size(), 2);
        for (int k = 0; k < 2; k++) refm[32'h0000_6800 + 32'(4*k)] = w[32*k +: 32];

        // Asynchronous reset while in RF.
        preload(32'h0000_5000, {$urandom, $urandom, $urandom, $urandom});
        miss_addr = 32'h0000_5000; dirty = 1'b0; miss_req = 1'b1;
        @(posedge clk); #1;
        miss_req = 1'b0;
        @(posedge clk); #2;
        chk("rf_before_reset", mem_read, 1'b1);
        rst = 1'b0;
        #1;
        chk("areset_flags", {miss_ack, refill_valid, busy, err, mem_read, mem_write, mem_clr}, 7'd0);
        chk("areset_addr_refill", {mem_addr, refill_data}, 160'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        run_miss(32'h0000_5004, 1'b0, 32'd0, 128'd0, 1'b0);

        // Randomized misses against the reference memory.
        for (int i = 0; i < 12; i++) begin
            ma = {16'h0001, 12'($urandom), 4'($urandom)};
            va = ($urandom_range(0, 3) == 0) ? ma : {16'h0002, 12'($urandom), 4'($urandom)};
            run_miss(ma, 1'($urandom), va, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_miss_handler.md
# mem_miss_handler

Cache-miss sequencer between the data cache controller and the 128-bit banked main memory (`mem128b`). On a miss it optionally writes back a dirty 128-bit victim line as four single-word memory writes, then reads the missing line as one 128-bit block. It returns the line to the controller with a one-cycle valid/ack pulse and flags a memory timeout as a sticky error.

## Interface
Parameters:
- MEM_TIMEOUT, 16: max cycles per memory access before error; legal range 4..255.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous abort; returns the block to IDLE and clears err.
- miss_req  in  1  miss request; sampled only in IDLE.
- miss_addr  in  32  byte address of the missing line.
- dirty  in  1  victim line needs writeback.
- victim_addr  in  32  byte address of the victim line.
- victim_data  in  128  victim line; word k is bits [32k+31:32k].
- miss_ack  out  1  one-cycle pulse: miss serviced.
- refill_valid  out  1  one-cycle pulse: refill_data valid (same cycle as miss_ack).
- refill_data  out  128  registered refill line; holds its value until the next refill.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky timeout flag.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write word.
- mem_block_rdata  in  128  memory block read data.
- mem_ready  in  1  memory ready; idles high, goes low while an access is in progress.
- mem_clr  out  1  memory latency-counter clear.

## Operation
- States: IDLE, WB, WB_GAP, RF, DONE, ERR.
- IDLE:
  - On miss_req=1, latch miss_addr, dirty, victim_addr and victim_data, and set word index k=0.
  - Go to WB if dirty=1, else RF.
  - miss_req is ignored while busy=1. It is never queued.
- WB: mem_write=1, mem_addr={victim_addr[31:4],k,2'b00}, mem_wdata=victim word k. On access completion go to WB_GAP.
- WB_GAP: all requests low for one cycle. Then k+1 and return to WB if k<3; if k=3, go to RF.
- RF: mem_read=1, mem_addr={miss_addr[31:4],4'b0000}. On completion, capture mem_block_rdata into refill_data and go to DONE.
- DONE: miss_ack=1 and refill_valid=1 for one cycle, then IDLE.
- Access completion:
  - A seen_low flag clears when a request is first asserted.
  - seen_low sets when mem_ready=0 is sampled with the request high.
  - The access completes on the first cycle with mem_ready=1 and seen_low=1. A mem_ready=1 seen before any low sample is ignored.
- Timeout:
  - A per-access 8-bit counter starts at 0 when the request is asserted and increments every cycle.
  - If the count reaches MEM_TIMEOUT without completion, go to ERR.
  - ERR: err=1, busy=1, all requests low, no miss_ack. The block stays in ERR until clr.
- mem_clr: registered; high for exactly one cycle after clr is sampled high or after timeout detection.
- clr is sampled high in any state:
  - next state is IDLE; requests drop, err clears, counters clear;
  - refill_data is retained; no ack is issued.
- Reset: state IDLE, refill_data=0. Every output is 0 except mem_addr=0 and mem_wdata=0.

## Timing
- Every request and data output is registered from state; none is combinational from inputs.
- Against a 3-cycle memory, each access holds its request for 4 cycles: ready high, low, low, then high (complete).
- Clean miss accepted in cycle 0: RF in cycles 1–4, DONE in cycle 5, IDLE in cycle 6.
- Dirty miss: 4 × (4 request + 1 gap) = cycles 1–20, RF in cycles 21–24, DONE in cycle 25.
- mem_addr and mem_wdata are stable for the whole time a request is high.
- A new miss_req is accepted no earlier than the cycle after DONE.
- Asynchronous reset mid-access drops all requests immediately. No partial write is retried.

## Structure
- Package mem_miss_pkg holds:
  - the state enum;
  - LINE_BYTES=16 and WORDS_PER_LINE=4;
  - DEFAULT_MEM_TIMEOUT=16;
  - a word-select function for victim data.
- One sub-module, mem_access_tracker: holds the seen_low flag and the timeout counter, and outputs complete and timeout.

## Test plan
- Clean miss, miss_addr=0x0000_1234, memory preloaded at 0x1230 with 0xDDDD…_AAAA… → one mem_read at 0x1230; refill_data matches and miss_ack/refill_valid pulse in cycle 5.
- Dirty miss, victim_addr=0x0000_2000, victim_data={W3,W2,W1,W0} → writes to 0x2000/4/8/C with W0..W3 in order, each followed by a gap cycle; refill completes in cycle 25; memory readback of 0x2000 equals victim_data.
- Memory held with mem_ready stuck high (no low sample) → no completion; err=1 after 16 cycles; one-cycle mem_clr; busy stays 1.
- err set, then clr pulsed → IDLE, err=0, busy=0; the next clean miss completes normally.
- Second miss_req asserted during a writeback → ignored; exactly one miss_ack. clr during WB word 2 → requests drop next cycle, no ack, refill_data unchanged.
- Asynchronous reset asserted in RF → all outputs 0 immediately; after release, a clean miss completes in 5 cycles.
